// File: rtl/otter_mem_dualport_mc.sv
// Dual-port OTTER memory: port 1 is a registered instruction fetch, port 2 a
// handshaked load/store port that splits word-crossing accesses into two beats.
module otter_mem_dualport_mc #(
  parameter int          WORD_AW          = 14,
  parameter logic [31:0] IO_BASE          = 32'h1100_0000,
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter              INIT_FILE        = "otter_memory.mem"
) (
  input  logic        MEM_CLK,
  input  logic        MEM_RST_N,
  input  logic        MEM_READ1,
  input  logic [31:0] MEM_ADDR1,
  output logic [31:0] MEM_DOUT1,
  input  logic        MEM_REQ2,
  input  logic        MEM_WE2,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_SIGN,
  input  logic [31:0] MEM_ADDR2,
  input  logic [31:0] MEM_DIN2,
  output logic        MEM_BUSY2,
  output logic        MEM_VALID2,
  output logic [31:0] MEM_DOUT2,
  input  logic [31:0] IO_IN,
  output logic        IO_WR,
  output logic        ERR
);

  localparam int          DEPTH   = 2 ** WORD_AW;
  localparam logic [30:0] DEPTH_W = 31'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SPLIT, S_DONE} state_t;

  state_t state_q, state_d;

  logic [31:0] mem [DEPTH];

  // Request register: everything about the access is frozen at accept.
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic        req_we;
  logic [31:0] req_din;
  logic [31:0] lo_q;
  logic [31:0] dout2_q;
  logic        err_q;

  logic [1:0]         off;
  logic [3:0]         span;
  logic               crossing;
  logic [29:0]        word_idx;
  logic [30:0]        next_idx;
  logic               is_io;
  logic               ram_oob;
  logic               err;
  logic               split_needed;
  logic [WORD_AW-1:0] w0, w1;
  logic [3:0]         size_mask;
  logic [7:0]         mask64;
  logic [63:0]        wdata64;

  logic               wr_en;
  logic [WORD_AW-1:0] wr_idx;
  logic [3:0]         wr_be;
  logic [31:0]        wr_data;
  logic [WORD_AW-1:0] rd_idx;
  logic [31:0]        rd_word;
  logic               busy;
  logic               io_wr;

  logic unused_addr1_bits;
  assign unused_addr1_bits = ^{MEM_ADDR1[31:WORD_AW+2], MEM_ADDR1[1:0]};

  // Access decode, all from the frozen request.
  assign off          = req_addr[1:0];
  assign span         = 4'd1 << req_size;
  assign crossing     = ({2'b00, off} + span) > 4'd4;
  assign word_idx     = req_addr[31:2];
  assign next_idx     = {1'b0, word_idx} + 31'd1;
  assign is_io        = req_addr >= IO_BASE;
  assign ram_oob      = !is_io && (({1'b0, word_idx} >= DEPTH_W) || (crossing && next_idx >= DEPTH_W));
  assign err          = (req_size == 2'd3) || ram_oob || (crossing && !ALLOW_MISALIGNED);
  assign split_needed = crossing && !is_io && !err;
  assign w0           = req_addr[WORD_AW+1:2];
  assign w1           = w0 + WORD_AW'(1);

  always_comb begin
    case (req_size)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Two adjacent words seen as one 64-bit lane: low half is beat 1, high half beat 2.
  assign mask64  = {4'b0000, size_mask} << off;
  assign wdata64 = {32'h0, req_din} << {off, 3'b000};

  function automatic logic [31:0] load_extend(input logic [63:0] pair, input logic [1:0] a,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] raw;
    raw = 32'(pair >> {a, 3'b000});
    case (size)
      2'd0:    load_extend = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    load_extend = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: load_extend = raw;
    endcase
  endfunction

  always_ff @(posedge MEM_CLK) begin
    if (!MEM_RST_N) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    state_d = state_q;
    busy    = 1'b1;
    io_wr   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = w0;
    wr_be   = mask64[3:0];
    wr_data = wdata64[31:0];
    rd_idx  = w0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (MEM_REQ2) state_d = S_ACC;
      end
      S_ACC: begin
        if (!err && req_we) begin
          if (is_io) io_wr = 1'b1;
          else       wr_en = 1'b1;
        end
        state_d = split_needed ? S_SPLIT : S_DONE;
      end
      S_SPLIT: begin
        rd_idx  = w1;
        wr_idx  = w1;
        wr_be   = mask64[7:4];
        wr_data = wdata64[63:32];
        wr_en   = req_we;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_word    = mem[rd_idx];
  assign MEM_BUSY2  = busy;
  assign MEM_VALID2 = (state_q == S_DONE);
  assign IO_WR      = io_wr;
  assign MEM_DOUT2  = dout2_q;
  assign ERR        = err_q;

  always_ff @(posedge MEM_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!MEM_RST_N) begin
      req_addr <= '0;
      req_size <= '0;
      req_sign <= 1'b0;
      req_we   <= 1'b0;
      req_din  <= '0;
      lo_q     <= '0;
      dout2_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (MEM_REQ2) begin
            req_addr <= MEM_ADDR2;
            req_size <= MEM_SIZE;
            req_sign <= MEM_SIGN;
            req_we   <= MEM_WE2;
            req_din  <= MEM_DIN2;
          end
        end
        S_ACC: begin
          lo_q  <= rd_word;
          err_q <= err;
          if (err || req_we)      dout2_q <= '0;
          else if (is_io)         dout2_q <= IO_IN;
          else if (!split_needed) dout2_q <= load_extend({32'h0, rd_word}, off, req_size, req_sign);
        end
        S_SPLIT: begin
          if (req_we) dout2_q <= '0;
          else        dout2_q <= load_extend({rd_word, lo_q}, off, req_size, req_sign);
        end
        default: ;
      endcase
    end
  end

  // Port 1 reads before the port-2 write in the same edge lands (read-first).
  always_ff @(posedge MEM_CLK) begin
    if (!MEM_RST_N)     MEM_DOUT1 <= '0;
    else if (MEM_READ1) MEM_DOUT1 <= mem[MEM_ADDR1[WORD_AW+1:2]];
  end

  // NOTE: the RAM array has no reset; reset only blocks a write, so a split store interrupted mid-way keeps beat 1.
  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST_N && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_otter_mem_dualport_mc.sv
// Directed bench: instance A splits crossing accesses, instance B (small, strict) flags them.
module tb_otter_mem_dualport_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read1;
  logic [31:0] addr1;
  logic        we2;
  logic [1:0]  size2;
  logic        sign2;
  logic [31:0] addr2;
  logic [31:0] din2;
  logic [31:0] io_in;
  logic        req_a, req_b;

  logic [31:0] dout1_a, dout2_a, dout1_b, dout2_b;
  logic        busy_a, valid_a, io_wr_a, err_a;
  logic        busy_b, valid_b, io_wr_b, err_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  otter_mem_dualport_mc #(.WORD_AW(14), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .MEM_CLK(clk), .MEM_RST_N(rst_n), .MEM_READ1(read1), .MEM_ADDR1(addr1), .MEM_DOUT1(dout1_a),
    .MEM_REQ2(req_a), .MEM_WE2(we2), .MEM_SIZE(size2), .MEM_SIGN(sign2), .MEM_ADDR2(addr2),
    .MEM_DIN2(din2), .MEM_BUSY2(busy_a), .MEM_VALID2(valid_a), .MEM_DOUT2(dout2_a),
    .IO_IN(io_in), .IO_WR(io_wr_a), .ERR(err_a));

  otter_mem_dualport_mc #(.WORD_AW(10), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .MEM_CLK(clk), .MEM_RST_N(rst_n), .MEM_READ1(read1), .MEM_ADDR1(addr1), .MEM_DOUT1(dout1_b),
    .MEM_REQ2(req_b), .MEM_WE2(we2), .MEM_SIZE(size2), .MEM_SIGN(sign2), .MEM_ADDR2(addr2),
    .MEM_DIN2(din2), .MEM_BUSY2(busy_b), .MEM_VALID2(valid_b), .MEM_DOUT2(dout2_b),
    .IO_IN(io_in), .IO_WR(io_wr_b), .ERR(err_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One port-2 transaction; returns result, error, cycles from accept to VALID and IO_WR cycles seen.
  task automatic op(input bit sel_b, input bit we, input logic [1:0] size, input bit uns,
                    input logic [31:0] addr, input logic [31:0] din,
                    output logic [31:0] dout, output logic e, output int lat, output int iowr);
    bit seen;
    @(negedge clk);
    we2 = we; size2 = size; sign2 = uns; addr2 = addr; din2 = din;
    if (sel_b) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    lat = 0; iowr = 0; seen = 1'b0; dout = 'x; e = 1'bx;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (sel_b ? io_wr_b : io_wr_a) iowr++;
      if (sel_b ? valid_b : valid_a) begin
        seen = 1'b1;
        dout = sel_b ? dout2_b : dout2_a;
        e    = sel_b ? err_b : err_a;
      end
    end
  endtask

  task automatic rd1(input logic [31:0] addr, output logic [31:0] da, output logic [31:0] db);
    @(negedge clk);
    read1 = 1'b1; addr1 = addr;
    @(posedge clk); #1;
    read1 = 1'b0;
    da = dout1_a; db = dout1_b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, da, db;
    logic        e;
    int          lat, iowr, vcount;

    rst_n = 1'b0; read1 = 1'b0; addr1 = '0; we2 = 1'b0; size2 = 2'd0; sign2 = 1'b0;
    addr2 = '0; din2 = '0; io_in = '0; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dout1", dout1_a, 32'h0);
    check("rst_dout2", dout2_a, 32'h0);
    check("rst_flags", {28'h0, busy_a, valid_a, io_wr_a, err_a}, 32'h0);
    check("rst_flags_b", {30'h0, busy_b, valid_b}, 32'h0);
    rst_n = 1'b1;

    // Aligned store then load.
    op(0, 1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF, d, e, lat, iowr);
    check("sw_lat", lat, 2);
    check("sw_dout_err", {d[30:0], e}, 32'h0);
    op(0, 0, 2'd2, 0, 32'h100, 32'h0, d, e, lat, iowr);
    check("lw_lat", lat, 2);
    check("lw_data", d, 32'hDEAD_BEEF);
    check("lw_err", e, 0);

    // Word-crossing load.
    op(0, 1, 2'd2, 0, 32'h100, 32'h4433_2211, d, e, lat, iowr);
    op(0, 1, 2'd2, 0, 32'h104, 32'h8877_6655, d, e, lat, iowr);
    op(0, 0, 2'd2, 0, 32'h102, 32'h0, d, e, lat, iowr);
    check("lw_cross_lat", lat, 3);
    check("lw_cross_data", d, 32'h6655_4433);
    check("lw_cross_err", e, 0);

    // Word-crossing halfword store and loads.
    op(0, 1, 2'd1, 0, 32'h103, 32'h0000_ABCD, d, e, lat, iowr);
    check("sh_cross_lat", lat, 3);
    rd1(32'h100, da, db);
    check("sh_cross_w0", da, 32'hCD33_2211);
    rd1(32'h104, da, db);
    check("sh_cross_w1", da, 32'h8877_66AB);
    op(0, 0, 2'd1, 0, 32'h103, 32'h0, d, e, lat, iowr);
    check("lh_cross", d, 32'hFFFF_ABCD);
    op(0, 0, 2'd1, 1, 32'h103, 32'h0, d, e, lat, iowr);
    check("lhu_cross", d, 32'h0000_ABCD);
    op(0, 0, 2'd0, 0, 32'h101, 32'h0, d, e, lat, iowr);
    check("lb_pos", d, 32'h0000_0022);
    op(0, 0, 2'd0, 0, 32'h103, 32'h0, d, e, lat, iowr);
    check("lb_neg", d, 32'hFFFF_FFCD);
    op(0, 0, 2'd0, 1, 32'h103, 32'h0, d, e, lat, iowr);
    check("lbu", d, 32'h0000_00CD);
    op(0, 1, 2'd0, 0, 32'h106, 32'hFFFF_FF7E, d, e, lat, iowr);
    check("sb_iowr", iowr, 0);
    rd1(32'h104, da, db);
    check("sb_word", da, 32'h887E_66AB);

    // IO window: word 0 aliases the IO base in RAM index bits and must stay untouched.
    op(0, 1, 2'd2, 0, 32'h0, 32'h0BAD_F00D, d, e, lat, iowr);
    op(0, 1, 2'd2, 0, 32'h1100_0000, 32'h0000_005A, d, e, lat, iowr);
    check("io_sw_lat", lat, 2);
    check("io_sw_iowr", iowr, 1);
    check("io_sw_err", e, 0);
    rd1(32'h0, da, db);
    check("io_sw_ram", da, 32'h0BAD_F00D);
    io_in = 32'h0000_1234;
    op(0, 0, 2'd2, 0, 32'h1100_0000, 32'h0, d, e, lat, iowr);
    check("io_lw", d, 32'h0000_1234);
    check("io_lw_iowr", iowr, 0);
    io_in = 32'hFFFF_FF80;
    op(0, 0, 2'd0, 1, 32'h1100_0001, 32'h0, d, e, lat, iowr);
    check("io_lbu_raw", d, 32'hFFFF_FF80);

    // Errors on instance A.
    op(0, 0, 2'd3, 0, 32'h100, 32'h0, d, e, lat, iowr);
    check("a_size3_err", e, 1);
    check("a_size3_dout", d, 32'h0);
    op(0, 0, 2'd2, 0, 32'h0001_0000, 32'h0, d, e, lat, iowr);
    check("a_oob_err", e, 1);
    op(0, 0, 2'd2, 0, 32'h0000_FFFE, 32'h0, d, e, lat, iowr);
    check("a_oob2_err", e, 1);
    check("a_oob2_lat", lat, 2);
    op(0, 1, 2'd2, 0, 32'h0000_FFFC, 32'h1357_9BDF, d, e, lat, iowr);
    op(0, 0, 2'd2, 0, 32'h0000_FFFC, 32'h0, d, e, lat, iowr);
    check("a_top_word", d, 32'h1357_9BDF);
    check("a_top_err", e, 0);

    // Instance B: crossing is an error and writes nothing.
    op(1, 1, 2'd2, 0, 32'h100, 32'h0102_0304, d, e, lat, iowr);
    check("b_sw_err", e, 0);
    op(1, 1, 2'd2, 0, 32'h102, 32'h1111_1111, d, e, lat, iowr);
    check("b_sw_cross_err", e, 1);
    check("b_sw_cross_lat", lat, 2);
    rd1(32'h100, da, db);
    check("b_no_write", db, 32'h0102_0304);
    op(1, 0, 2'd2, 0, 32'h102, 32'h0, d, e, lat, iowr);
    check("b_lw_cross_err", e, 1);
    check("b_lw_cross_dout", d, 32'h0);
    op(1, 0, 2'd3, 0, 32'h100, 32'h0, d, e, lat, iowr);
    check("b_size3_err", e, 1);
    op(1, 0, 2'd2, 0, 32'h0000_1000, 32'h0, d, e, lat, iowr);
    check("b_oob_err", e, 1);

    // Reset during the second beat of a split store.
    op(0, 1, 2'd2, 0, 32'h100, 32'h4433_2211, d, e, lat, iowr);
    op(0, 1, 2'd2, 0, 32'h104, 32'h8877_6655, d, e, lat, iowr);
    @(negedge clk);
    we2 = 1'b1; size2 = 2'd1; sign2 = 1'b0; addr2 = 32'h103; din2 = 32'h0000_9876; req_a = 1'b1;
    @(posedge clk); #1 req_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("split_busy", busy_a, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_split_flags", {30'h0, busy_a, valid_a}, 32'h0);
    check("rst_split_dout2", dout2_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd1(32'h100, da, db);
    check("rst_split_w0", da, 32'h7633_2211);
    rd1(32'h104, da, db);
    check("rst_split_w1", da, 32'h8877_6655);

    // Read-first conflict, with MEM_REQ2 held high while busy.
    @(negedge clk);
    we2 = 1'b1; size2 = 2'd2; sign2 = 1'b0; addr2 = 32'h100; din2 = 32'hCAFE_F00D; req_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    read1 = 1'b1; addr1 = 32'h100;
    @(posedge clk); #1 read1 = 1'b0;
    check("read_first", dout1_a, 32'h7633_2211);
    vcount = 0;
    @(negedge clk);
    if (valid_a) vcount++;
    @(posedge clk); #1 req_a = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (valid_a) vcount++;
    end
    check("no_queue_valid", vcount, 1);
    rd1(32'h100, da, db);
    check("after_conflict", da, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
